// File: rtl/response_router_pkg.sv
// Shared definitions for the arbiter return path: default sizing and the
// requester index encoding used by both the arbiter side and the router.
package response_router_pkg;

    localparam int RR_NUM_REQUESTERS  = 4;
    localparam int RR_MAX_OUTSTANDING = 8;
    localparam int RR_DATA_WIDTH      = 32;
    localparam int RR_IDX_W           = (RR_NUM_REQUESTERS > 1) ? $clog2(RR_NUM_REQUESTERS) : 1;

    typedef logic [RR_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/response_router_if.sv
// Issue/response bus between the arbiter + shared resource (master) and the router (slave).
interface response_router_if
    import response_router_pkg::*;
#(
    parameter int NUM_REQUESTERS  = RR_NUM_REQUESTERS,
    parameter int MAX_OUTSTANDING = RR_MAX_OUTSTANDING,
    parameter int DATA_WIDTH      = RR_DATA_WIDTH
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      issue;
    logic                      can_issue;
    logic                      response_valid;
    logic [DATA_WIDTH-1:0]     response_data;
    logic [NUM_REQUESTERS-1:0] resp_valid_oh;
    logic [DATA_WIDTH-1:0]     resp_data;
    logic [CNT_W-1:0]          outstanding;
    logic                      protocol_error;

    modport master (
        output grant_oh, issue, response_valid, response_data,
        input  can_issue, resp_valid_oh, resp_data, outstanding, protocol_error
    );

    modport slave (
        input  grant_oh, issue, response_valid, response_data,
        output can_issue, resp_valid_oh, resp_data, outstanding, protocol_error
    );

endinterface

// File: rtl/response_router_oh_to_idx.sv
// One-hot to binary index encoder; output bit b is the OR of every input whose index has bit b set.
module response_router_oh_to_idx #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     oh,
    output logic [IDX_W-1:0] idx
);

    for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bit
        logic [N-1:0] sel;
        for (genvar gj = 0; gj < N; gj++) begin : g_src
            if (((gj >> gi) & 1) == 1) begin : g_on
                assign sel[gj] = oh[gj];
            end else begin : g_off
                assign sel[gj] = 1'b0;
            end
        end
        assign idx[gi] = |sel;
    end

endmodule

// File: rtl/response_router.sv
// Records the winning requester of each accepted issue in an in-order tag FIFO
// and steers each returning response back to that requester one cycle later.
module response_router
    import response_router_pkg::*;
#(
    parameter int NUM_REQUESTERS  = RR_NUM_REQUESTERS,
    parameter int MAX_OUTSTANDING = RR_MAX_OUTSTANDING,
    parameter int DATA_WIDTH      = RR_DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    response_router_if.slave bus
);

    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]          FULL_COUNT = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]          PTR_ONE    = PTR_W'(1);
    localparam logic [NUM_REQUESTERS-1:0] ONE_N      = NUM_REQUESTERS'(1);

    logic [IDX_W-1:0]          tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]          wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]          count_reg, count_next;
    logic                      error_reg;
    logic [NUM_REQUESTERS-1:0] resp_valid_reg;
    logic [DATA_WIDTH-1:0]     resp_data_reg;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_onehot;
    logic             full, empty, push, pop, error_event;

    response_router_oh_to_idx #(
        .N     (NUM_REQUESTERS),
        .IDX_W (IDX_W)
    ) u_oh_to_idx (
        .oh  (bus.grant_oh),
        .idx (grant_idx)
    );

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign grant_onehot = (bus.grant_oh != '0) && ((bus.grant_oh & (bus.grant_oh - ONE_N)) == '0);

    // Full/empty come from the registered count only, so a pop never frees a slot in the same cycle.
    assign full        = (count_reg == FULL_COUNT);
    assign empty       = (count_reg == '0);
    assign push        = bus.issue && grant_onehot && !full;
    assign pop         = bus.response_valid && !empty;
    assign error_event = (bus.issue && (!grant_onehot || full)) || (bus.response_valid && empty);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_ONE;
            2'b01:   count_next = count_reg - CNT_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            error_reg      <= 1'b0;
            resp_valid_reg <= '0;
            resp_data_reg  <= '0;
        end else begin
            count_reg <= count_next;
            error_reg <= error_reg || error_event;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + PTR_ONE;
                resp_valid_reg <= ONE_N << tag_mem[rd_ptr_reg];
                resp_data_reg  <= bus.response_data;
            end else begin
                resp_valid_reg <= '0;
            end
        end
    end

    assign bus.can_issue      = !full;
    assign bus.outstanding    = count_reg;
    assign bus.protocol_error = error_reg;
    assign bus.resp_valid_oh  = resp_valid_reg;
    assign bus.resp_data      = resp_data_reg;

endmodule

// File: tb/tb_response_router.sv
// Bench for response_router: directed scenarios plus random traffic, compared
// against a queue-based model of the in-order tag FIFO.
module tb_response_router;

    localparam int N    = 4;
    localparam int MAXO = 8;
    localparam int DW   = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    response_router_if #(.NUM_REQUESTERS(N), .MAX_OUTSTANDING(MAXO), .DATA_WIDTH(DW)) bus ();

    response_router #(.NUM_REQUESTERS(N), .MAX_OUTSTANDING(MAXO), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: the queue of outstanding requester numbers, the sticky flag and the held payload.
    int          mq[$];
    bit          m_err;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] g);
        int w = 0;
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        return w;
    endfunction

    task automatic step(input logic iss, input logic [N-1:0] g, input logic rv, input logic [DW-1:0] rd);
        bit          was_full, was_empty, legal;
        logic [N-1:0] exp_valid;
        bus.issue          = iss;
        bus.grant_oh       = g;
        bus.response_valid = rv;
        bus.response_data  = rd;
        was_full  = (mq.size() == MAXO);
        was_empty = (mq.size() == 0);
        legal     = ($countones(g) == 1);
        exp_valid = '0;
        if (rv && !was_empty) begin
            exp_valid = N'(1 << mq.pop_front());
            m_data    = rd;
        end
        if (rv && was_empty) m_err = 1'b1;
        if (iss && (!legal || was_full)) m_err = 1'b1;
        if (iss && legal && !was_full) mq.push_back(winner(g));
        @(posedge clk);
        #1;
        $display("t=%0t iss=%b g=%b rv=%b rd=%h -> v=%b d=%h out=%0d ci=%b err=%b", $time, iss, g, rv, rd,
                 bus.resp_valid_oh, bus.resp_data, bus.outstanding, bus.can_issue, bus.protocol_error);
        check("resp_valid_oh", 64'(bus.resp_valid_oh), 64'(exp_valid));
        check("resp_data", 64'(bus.resp_data), 64'(m_data));
        check("outstanding", 64'(bus.outstanding), 64'(mq.size()));
        check("can_issue", 64'(bus.can_issue), 64'(mq.size() != MAXO));
        check("protocol_error", 64'(bus.protocol_error), 64'(m_err));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    // Assert reset asynchronously from wherever we are, confirm outputs cleared before any clock edge.
    task automatic do_reset();
        reset              = 1'b0;
        bus.issue          = 1'b0;
        bus.grant_oh       = '0;
        bus.response_valid = 1'b0;
        bus.response_data  = '0;
        mq.delete();
        m_err  = 1'b0;
        m_data = '0;
        #1;
        $display("t=%0t reset asserted -> v=%b d=%h out=%0d ci=%b err=%b", $time,
                 bus.resp_valid_oh, bus.resp_data, bus.outstanding, bus.can_issue, bus.protocol_error);
        check("rst_valid", 64'(bus.resp_valid_oh), 64'd0);
        check("rst_data", 64'(bus.resp_data), 64'd0);
        check("rst_outstanding", 64'(bus.outstanding), 64'd0);
        check("rst_can_issue", 64'(bus.can_issue), 64'd1);
        check("rst_error", 64'(bus.protocol_error), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] g;
        logic         iss, rv;
        int           p_iss, p_rv;

        do_reset();

        // Single round trip
        step(1'b1, 4'b0100, 1'b0, '0);
        idle(2);
        step(1'b0, '0, 1'b1, 32'hA5A5_0001);
        idle(1);

        // Ordering
        for (int i = 0; i < 5; i++) step(1'b1, N'(1 << (i % N)), 1'b0, '0);
        for (int i = 1; i <= 5; i++) step(1'b0, '0, 1'b1, DW'(i));
        idle(1);

        // Fill, overflow attempt, then sustained push+pop across pointer wrap
        for (int i = 0; i < MAXO; i++) step(1'b1, N'(1 << $urandom_range(N - 1)), 1'b0, '0);
        step(1'b1, 4'b0010, 1'b0, '0);
        step(1'b0, '0, 1'b1, $urandom);
        for (int i = 0; i < 20; i++) step(1'b1, N'(1 << $urandom_range(N - 1)), 1'b1, $urandom);
        for (int i = 0; i < MAXO; i++) step(1'b0, '0, 1'b1, $urandom);
        do_reset();

        // Simultaneous push and pop at outstanding=3
        step(1'b1, 4'b1000, 1'b0, '0);
        step(1'b1, 4'b0001, 1'b0, '0);
        step(1'b1, 4'b0100, 1'b0, '0);
        step(1'b1, 4'b0010, 1'b1, 32'h0000_0033);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, DW'(32'h100 + i));
        idle(1);

        // Error cases: response while empty, multi-hot grant, response in same cycle as first push
        step(1'b0, '0, 1'b1, 32'hDEAD_0000);
        step(1'b1, 4'b0110, 1'b0, '0);
        step(1'b1, 4'b0000, 1'b0, '0);
        idle(3);
        step(1'b1, 4'b0001, 1'b1, 32'hBEEF_0000);
        step(1'b0, '0, 1'b1, 32'hBEEF_0001);
        idle(2);
        do_reset();

        // Reset mid-operation with a delivery on the outputs
        for (int i = 0; i < 6; i++) step(1'b1, N'(1 << (i % N)), 1'b0, '0);
        step(1'b0, '0, 1'b1, 32'h5555_AAAA);
        #2;
        do_reset();
        idle(3);

        // Random traffic with changing issue/response bias and periodic reset
        for (int blk = 0; blk < 8; blk++) begin
            p_iss = $urandom_range(30, 90);
            p_rv  = $urandom_range(30, 90);
            for (int c = 0; c < 40; c++) begin
                iss = ($urandom_range(99) < p_iss);
                g   = ($urandom_range(19) == 0) ? N'($urandom_range(15)) : N'(1 << $urandom_range(N - 1));
                if (mq.size() > 0) rv = ($urandom_range(99) < p_rv);
                else               rv = ($urandom_range(49) == 0);
                step(iss, g, rv, $urandom);
            end
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
